data_mem_arbiter: RTL and testbench

// Shares one req/gnt/rvalid data-memory slave (data_memory) between NUM_REQ requesters (core LSU, debug/trace port).

---
 rtl/data_mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_data_mem_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid data-memory slave between NUM_REQ requesters.
// One transaction in flight; an optional response timeout errors the owner and drains the late reply.
module data_mem_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    m_req_i,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    m_addr_i,
  input  logic [NUM_REQ-1:0]                    m_we_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0]  m_be_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    m_wdata_i,
  output logic [NUM_REQ-1:0]                    m_gnt_o,
  output logic [NUM_REQ-1:0]                    m_rvalid_o,
  output logic [DATA_WIDTH-1:0]                 m_rdata_o,
  output logic [NUM_REQ-1:0]                    m_err_o,
  output logic                                  mem_req_o,
  output logic [ADDR_WIDTH-1:0]                 mem_addr_o,
  output logic                                  mem_we_o,
  output logic [DATA_WIDTH/8-1:0]               mem_be_o,
  output logic [DATA_WIDTH-1:0]                 mem_wdata_o,
  input  logic                                  mem_gnt_i,
  input  logic                                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                 mem_rdata_i,
  input  logic                                  mem_err_i,
  output logic                                  busy_o
);

  localparam int unsigned OW = $clog2(NUM_REQ);
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [OW-1:0] LAST_REQ = OW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e        state_q;
  logic [OW-1:0] owner_q;
  logic [OW-1:0] rr_q;
  logic [CW-1:0] cnt_q;

  logic [OW-1:0] pick;
  logic          pick_vld;
  int unsigned   idx;
  logic [OW-1:0] rr_d;
  logic          resp_hit;
  logic          to_hit;

  // Search starts at rr_q and wraps, so the requester just served drops to lowest priority.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    idx      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(rr_q) + i) % NUM_REQ;
      if (!pick_vld && m_req_i[idx]) begin
        pick_vld = 1'b1;
        pick     = OW'(idx);
      end
    end
  end

  assign rr_d     = (owner_q == LAST_REQ) ? '0 : owner_q + OW'(1);
  assign resp_hit = (state_q == RESP) && mem_rvalid_i;
  assign to_hit   = (TIMEOUT != 0) && (state_q == RESP) && !mem_rvalid_i && (cnt_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            owner_q <= pick;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            cnt_q   <= '0;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (mem_rvalid_i) begin
            rr_q    <= rr_d;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            if (to_hit) begin
              rr_q    <= rr_d;
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (mem_rvalid_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // gnt/rvalid pass straight through; everything is forced low while rst is asserted.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    m_gnt_o     = '0;
    m_rvalid_o  = '0;
    m_rdata_o   = '0;
    m_err_o     = '0;
    if (!rst) begin
      if (state_q == REQ) begin
        mem_req_o        = 1'b1;
        mem_addr_o       = m_addr_i[owner_q];
        mem_we_o         = m_we_i[owner_q];
        mem_be_o         = m_be_i[owner_q];
        mem_wdata_o      = m_wdata_i[owner_q];
        m_gnt_o[owner_q] = mem_gnt_i;
      end
      if (resp_hit) begin
        m_rvalid_o[owner_q] = 1'b1;
        m_rdata_o           = mem_rdata_i;
        m_err_o[owner_q]    = mem_err_i;
      end else if (to_hit) begin
        m_rvalid_o[owner_q] = 1'b1;
        m_err_o[owner_q]    = 1'b1;
      end
    end
  end

  assign busy_o = !rst && (state_q != IDLE);

  a_gnt_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(m_gnt_o));
  a_rvalid_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(m_rvalid_o));
  a_err_qualified : assert property (@(posedge clk) disable iff (rst) (m_err_o & ~m_rvalid_o) == '0);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: per-cycle vector table plus sequences for
// fairness, timeout/drain and reset-while-busy.
module tb_data_mem_arbiter;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        m_req_i;
  logic [1:0][31:0]  m_addr_i;
  logic [1:0]        m_we_i;
  logic [1:0][3:0]   m_be_i;
  logic [1:0][31:0]  m_wdata_i;
  logic [1:0]        m_gnt_o, m_rvalid_o, m_err_o;
  logic [31:0]       m_rdata_o;
  logic              mem_req_o, mem_we_o;
  logic [31:0]       mem_addr_o, mem_wdata_o;
  logic [3:0]        mem_be_o;
  logic              mem_gnt_i, mem_rvalid_i, mem_err_i;
  logic [31:0]       mem_rdata_i;
  logic              busy_o;

  int unsigned n_asserts = 0;
  int unsigned n_fail    = 0;

  data_mem_arbiter #(
    .NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .m_req_i(m_req_i), .m_addr_i(m_addr_i), .m_we_i(m_we_i), .m_be_i(m_be_i), .m_wdata_i(m_wdata_i),
    .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o), .m_err_o(m_err_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Fixed payloads: requester 0 reads 0x0, requester 1 writes 0xAAAA5555 to 0x4 with be=0011.
  localparam logic [31:0] A0 = 32'h0000_0000, D0 = 32'h1111_2222;
  localparam logic [31:0] A1 = 32'h0000_0004, D1 = 32'hAAAA_5555;
  localparam logic [3:0]  B0 = 4'hF, B1 = 4'h3;

  typedef struct {
    string       nm;
    logic        rst;
    logic [1:0]  req;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        err;
    logic        e_mreq;
    logic [31:0] e_addr;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [1:0]  e_gnt;
    logic [1:0]  e_rv;
    logic [31:0] e_rdata;
    logic [1:0]  e_err;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];

  // sel: 0 = no memory request, 1 = requester 0 payload, 2 = requester 1 payload
  function automatic vec_t mk(string nm, logic r, logic [1:0] rq, logic g, logic v, logic [31:0] rd,
                              logic e, int sel, logic [1:0] eg, logic [1:0] ev, logic [31:0] erd,
                              logic [1:0] ee, logic eb);
    vec_t t;
    t.nm = nm; t.rst = r; t.req = rq; t.gnt = g; t.rv = v; t.rdata = rd; t.err = e;
    t.e_mreq = (sel != 0);
    t.e_addr  = (sel == 1) ? A0 : (sel == 2) ? A1 : 32'h0;
    t.e_we    = (sel == 2);
    t.e_be    = (sel == 1) ? B0 : (sel == 2) ? B1 : 4'h0;
    t.e_wdata = (sel == 1) ? D0 : (sel == 2) ? D1 : 32'h0;
    t.e_gnt = eg; t.e_rv = ev; t.e_rdata = erd; t.e_err = ee; t.e_busy = eb;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic apply(input logic r, input logic [1:0] rq, input logic g, input logic v,
                       input logic [31:0] rd, input logic e);
    @(negedge clk);
    rst = r; m_req_i = rq; mem_gnt_i = g; mem_rvalid_i = v; mem_rdata_i = rd; mem_err_i = e;
    #1;
  endtask

  logic [127:0] got_v, exp_v;
  logic [1:0]   seen[4];
  int unsigned  nseen;

  initial begin
    rst = 1'b1; m_req_i = '0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0; mem_err_i = 0;
    m_addr_i[0] = A0; m_we_i[0] = 1'b0; m_be_i[0] = B0; m_wdata_i[0] = D0;
    m_addr_i[1] = A1; m_we_i[1] = 1'b1; m_be_i[1] = B1; m_wdata_i[1] = D1;

    //          name             rst req  g  v  rdata         e  sel gnt   rv    rdata         err   busy
    tbl.push_back(mk("rst0",        1, 2'b00, 0, 0, 32'h0,        0, 0, 2'b00, 2'b00, 32'h0,        2'b00, 0));
    tbl.push_back(mk("rst_gated",   1, 2'b01, 1, 1, 32'hFFFF,     1, 0, 2'b00, 2'b00, 32'h0,        2'b00, 0));
    tbl.push_back(mk("idle_req0",   0, 2'b01, 0, 0, 32'h0,        0, 0, 2'b00, 2'b00, 32'h0,        2'b00, 0));
    tbl.push_back(mk("req0_wait",   0, 2'b01, 0, 0, 32'h0,        0, 1, 2'b00, 2'b00, 32'h0,        2'b00, 1));
    tbl.push_back(mk("req0_gnt",    0, 2'b01, 1, 0, 32'h0,        0, 1, 2'b01, 2'b00, 32'h0,        2'b00, 1));
    tbl.push_back(mk("resp0_wait",  0, 2'b00, 0, 0, 32'h0,        0, 0, 2'b00, 2'b00, 32'h0,        2'b00, 1));
    tbl.push_back(mk("resp0_rv",    0, 2'b00, 0, 1, 32'hB000B1E5, 0, 0, 2'b00, 2'b01, 32'hB000B1E5, 2'b00, 1));
    tbl.push_back(mk("idle_both1",  0, 2'b11, 0, 0, 32'h0,        0, 0, 2'b00, 2'b00, 32'h0,        2'b00, 0));
    tbl.push_back(mk("req1_gnt",    0, 2'b11, 1, 0, 32'h0,        0, 2, 2'b10, 2'b00, 32'h0,        2'b00, 1));
    tbl.push_back(mk("resp1_rv",    0, 2'b11, 0, 1, 32'h5,        0, 0, 2'b00, 2'b10, 32'h5,        2'b00, 1));
    tbl.push_back(mk("idle_both2",  0, 2'b11, 0, 0, 32'h0,        0, 0, 2'b00, 2'b00, 32'h0,        2'b00, 0));
    tbl.push_back(mk("req0_gnt2",   0, 2'b11, 1, 0, 32'h0,        0, 1, 2'b01, 2'b00, 32'h0,        2'b00, 1));
    tbl.push_back(mk("resp0_err",   0, 2'b11, 0, 1, 32'h6,        1, 0, 2'b00, 2'b01, 32'h6,        2'b01, 1));
    tbl.push_back(mk("idle_both3",  0, 2'b11, 0, 0, 32'h0,        0, 0, 2'b00, 2'b00, 32'h0,        2'b00, 0));
    tbl.push_back(mk("req1_hold",   0, 2'b11, 0, 0, 32'h0,        0, 2, 2'b00, 2'b00, 32'h0,        2'b00, 1));
    tbl.push_back(mk("req1_wgnt",   0, 2'b11, 1, 0, 32'h0,        0, 2, 2'b10, 2'b00, 32'h0,        2'b00, 1));
    tbl.push_back(mk("resp_stgnt",  0, 2'b00, 1, 0, 32'h0,        0, 0, 2'b00, 2'b00, 32'h0,        2'b00, 1));
    tbl.push_back(mk("resp1_wack",  0, 2'b00, 0, 1, 32'hACED,     0, 0, 2'b00, 2'b10, 32'hACED,     2'b00, 1));
    tbl.push_back(mk("idle_stray",  0, 2'b00, 1, 1, 32'hDEAD,     1, 0, 2'b00, 2'b00, 32'h0,        2'b00, 0));
    tbl.push_back(mk("idle_quiet",  0, 2'b00, 0, 0, 32'h0,        0, 0, 2'b00, 2'b00, 32'h0,        2'b00, 0));

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].req, tbl[i].gnt, tbl[i].rv, tbl[i].rdata, tbl[i].err);
      got_v = 128'({mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
                    m_gnt_o, m_rvalid_o, m_rdata_o, m_err_o, busy_o});
      exp_v = 128'({tbl[i].e_mreq, tbl[i].e_addr, tbl[i].e_we, tbl[i].e_be, tbl[i].e_wdata,
                    tbl[i].e_gnt, tbl[i].e_rv, tbl[i].e_rdata, tbl[i].e_err, tbl[i].e_busy});
      chk(tbl[i].nm, got_v, exp_v);
    end

    // Timeout: requester 1 owns, memory never answers; error on the 8th RESP cycle, then drain.
    apply(0, 2'b10, 0, 0, 32'h0, 0);
    apply(0, 2'b10, 1, 0, 32'h0, 0);
    chk("to_gnt", 128'(m_gnt_o), 128'(2'b10));
    for (int k = 1; k <= 8; k++) begin
      apply(0, 2'b00, 0, 0, 32'hDEADBEEF, 1);
      if (k < 8) begin
        chk("to_wait_rv", 128'({m_rvalid_o, m_err_o, busy_o}), 128'({2'b00, 2'b00, 1'b1}));
      end else begin
        chk("to_fire", 128'({m_rvalid_o, m_err_o, m_rdata_o, busy_o}), 128'({2'b10, 2'b10, 32'h0, 1'b1}));
      end
    end
    apply(0, 2'b00, 0, 0, 32'h0, 0);
    chk("drain_wait", 128'({m_rvalid_o, busy_o, mem_req_o}), 128'({2'b00, 1'b1, 1'b0}));
    apply(0, 2'b00, 0, 1, 32'h1234, 0);
    chk("drain_drop", 128'({m_rvalid_o, m_rdata_o, busy_o}), 128'({2'b00, 32'h0, 1'b1}));
    apply(0, 2'b11, 0, 0, 32'h0, 0);
    chk("post_to_idle", 128'(busy_o), 128'(1'b0));
    apply(0, 2'b11, 1, 0, 32'h0, 0);
    chk("post_to_gnt", 128'({m_gnt_o, mem_addr_o}), 128'({2'b01, A0}));
    apply(0, 2'b00, 0, 1, 32'hCAFE, 0);
    chk("post_to_rv", 128'({m_rvalid_o, m_rdata_o, m_err_o}), 128'({2'b01, 32'hCAFE, 2'b00}));

    // Reset while requester 1 is in RESP: pointer must return to 0.
    apply(0, 2'b11, 0, 0, 32'h0, 0);
    apply(0, 2'b11, 1, 0, 32'h0, 0);
    chk("rr1_gnt", 128'(m_gnt_o), 128'(2'b10));
    apply(0, 2'b00, 0, 0, 32'h0, 0);
    apply(1, 2'b00, 0, 1, 32'hBAD, 1);
    chk("rst_in_resp", 128'({m_rvalid_o, m_err_o, busy_o, mem_req_o}), 128'({2'b00, 2'b00, 1'b0, 1'b0}));
    apply(0, 2'b00, 0, 1, 32'hBAD, 1);
    chk("stray_after_rst", 128'({m_rvalid_o, m_rdata_o, busy_o}), 128'({2'b00, 32'h0, 1'b0}));
    apply(0, 2'b11, 0, 0, 32'h0, 0);
    apply(0, 2'b11, 1, 0, 32'h0, 0);
    chk("rr_reset_gnt", 128'(m_gnt_o), 128'(2'b01));
    apply(0, 2'b00, 0, 1, 32'h0, 0);

    // Fairness: both held after reset, memory always ready -> owners 0,1,0,1.
    apply(1, 2'b00, 0, 0, 32'h0, 0);
    nseen = 0;
    for (int c = 0; c < 40 && nseen < 4; c++) begin
      apply(0, 2'b11, 1, 1, 32'h0, 0);
      chk("fair_not_both", 128'(m_gnt_o == 2'b11), 128'(1'b0));
      if (m_gnt_o != 2'b00) begin
        seen[nseen] = m_gnt_o;
        nseen++;
      end
    end
    chk("fair_count", 128'(nseen), 128'(4));
    chk("fair_order", 128'({seen[0], seen[1], seen[2], seen[3]}), 128'({2'b01, 2'b10, 2'b01, 2'b10}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
